uart_host_rx: RTL



---
 rtl/uart_host_pkg.sv | 25 ++
 rtl/sync_fifo_byte.sv | 63 ++++++
 rtl/uart_host_rx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_host_pkg.sv
// Shared encodings for the host-side UART receiver: RX state, register map, status bits.
// No logic; constants only.
// Imported by uart_host_rx and sync_fifo_byte.
package uart_host_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    localparam logic [5:0] REG_DATA = 6'd0;
    localparam logic [5:0] REG_STAT = 6'd1;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAMING   = 3;
    localparam int ST_PARITY    = 4;
    localparam int ST_COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo_byte.sv
// Byte FIFO, 2**AW deep, head byte visible combinationally on pop_dat_o.
// Latency: a push is visible at the head one cycle later.
// Backpressure: push when full and pop when empty are ignored; caller flags overrun.
module sync_fifo_byte
    import uart_host_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          push_i,
    input  logic [7:0]    push_dat_i,
    input  logic          pop_i,
    output logic [7:0]    pop_dat_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    localparam int DEPTH = 2 ** AW;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    // count never exceeds DEPTH, so its top bit alone means full
    assign full_o    = count_q[AW];
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_host_rx.sv
// Host UART receiver (8N1, or 8E1 with UART_HOST_RX_PARITY_EN) feeding a byte FIFO on a 32-bit word bus.
// Latency: read data registered, valid 1 cycle after the read_i rising edge; irq_o lags count by 1 cycle.
// Backpressure: none on the serial line; bytes arriving into a full FIFO are dropped and flagged overrun.
module uart_host_rx
    import uart_host_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [5:0]  addr_i,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic        rx_i,
    output logic        irq_o
);

    localparam int CTR_W = $clog2(CLKS_PER_BIT);
    localparam logic [CTR_W-1:0] CTR_FULL = CTR_W'(CLKS_PER_BIT - 1);
    localparam logic [CTR_W-1:0] CTR_HALF = CTR_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta_q;
    logic             rxs_q;
    rx_state_e        state_q, state_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             push;
    logic             fe_set;
    logic             read_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             ovr_q, fe_q;
    logic             irq_q;
    logic [31:0]      stat;
    logic             rd_edge;
    logic             clr_wr;
    logic             pop;
    logic [7:0]       head;
    logic             full, empty;
    logic [FIFO_AW:0] count;
    logic             unused_wdat;
`ifdef UART_HOST_RX_PARITY_EN
    logic             par_bad_q, par_bad_d;
    logic             pe_set;
    logic             pe_q;
`endif

    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        fe_set    = 1'b0;
`ifdef UART_HOST_RX_PARITY_EN
        par_bad_d = par_bad_q;
        pe_set    = 1'b0;
`endif
        if (state_q != RX_IDLE && state_q != RX_WAIT_HIGH && ctr_q != '0) begin
            ctr_d = ctr_q - CTR_W'(1);
        end else begin
            case (state_q)
                RX_IDLE: begin
                    if (!rxs_q) begin
                        ctr_d   = CTR_HALF;
                        state_d = RX_START;
                    end
                end
                RX_START: begin
                    if (!rxs_q) begin
                        ctr_d     = CTR_FULL;
                        bit_idx_d = 3'd0;
                        state_d   = RX_DATA;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end
                RX_DATA: begin
                    shreg_d   = {rxs_q, shreg_q[7:1]};
                    ctr_d     = CTR_FULL;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_HOST_RX_PARITY_EN
                        par_bad_d = 1'b0;
                        state_d   = RX_PARITY;
`else
                        state_d   = RX_STOP;
`endif
                    end
                end
`ifdef UART_HOST_RX_PARITY_EN
                RX_PARITY: begin
                    ctr_d   = CTR_FULL;
                    state_d = RX_STOP;
                    // even parity: the parity bit equals the XOR of the data bits
                    if (rxs_q != ^shreg_q) begin
                        pe_set    = 1'b1;
                        par_bad_d = 1'b1;
                    end
                end
`endif
                RX_STOP: begin
                    if (rxs_q) begin
`ifdef UART_HOST_RX_PARITY_EN
                        push = !par_bad_q;
`else
                        push = 1'b1;
`endif
                        state_d = RX_IDLE;
                    end else begin
                        fe_set  = 1'b1;
                        state_d = RX_WAIT_HIGH;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rxs_q) begin
                        state_d = RX_IDLE;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    assign rd_edge = read_i && !read_q;
    assign pop     = rd_edge && (addr_i == REG_DATA);
    assign clr_wr  = write_i && (addr_i == REG_STAT);

    always_comb begin
        stat                                = '0;
        stat[ST_NOT_EMPTY]                  = !empty;
        stat[ST_FULL]                       = full;
        stat[ST_OVERRUN]                    = ovr_q;
        stat[ST_FRAMING]                    = fe_q;
`ifdef UART_HOST_RX_PARITY_EN
        stat[ST_PARITY]                     = pe_q;
`endif
        stat[ST_COUNT_LSB +: FIFO_AW + 1]   = count;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_edge) begin
            case (addr_i)
                REG_DATA: rdata_d = empty ? 32'd0 : 32'(head);
                REG_STAT: rdata_d = stat;
                default:  rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= RX_IDLE;
            ctr_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            read_q    <= 1'b0;
            rdata_q   <= '0;
            ovr_q     <= 1'b0;
            fe_q      <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            ctr_q     <= ctr_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            read_q    <= read_i;
            rdata_q   <= rdata_d;
            // set takes priority over a same-cycle write-1-to-clear
            ovr_q     <= (ovr_q && !(clr_wr && data_i[ST_OVERRUN])) || (push && full);
            fe_q      <= (fe_q && !(clr_wr && data_i[ST_FRAMING])) || fe_set;
            irq_q     <= !empty;
        end
    end

`ifdef UART_HOST_RX_PARITY_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            par_bad_q <= 1'b0;
            pe_q      <= 1'b0;
        end else begin
            par_bad_q <= par_bad_d;
            pe_q      <= (pe_q && !(clr_wr && data_i[ST_PARITY])) || pe_set;
        end
    end
    assign unused_wdat = ^{data_i[31:ST_PARITY+1], data_i[ST_OVERRUN-1:0]};
`else
    assign unused_wdat = ^{data_i[31:ST_PARITY], data_i[ST_OVERRUN-1:0]};
`endif

    sync_fifo_byte #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .push_i     (push),
        .push_dat_i (shreg_q),
        .pop_i      (pop),
        .pop_dat_o  (head),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count)
    );

    assign data_o = rdata_q;
    assign irq_o  = irq_q;

endmodule
